// File: rtl/bit_counter.sv
// Sequential ones-counter: captures an operand while idle, then counts its 1 bits
// by repeated right shift, presenting the count with a level done handshake.
module bit_counter #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N + 1)
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic [N-1:0] A,
  input  logic         s,
  output logic [W-1:0] result,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_a;
  logic [N-1:0]   w_a_nxt;
  logic [W-1:0]   r_result;
  logic [W-1:0]   w_result_nxt;
  logic           r_done;

  // State register
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath next values; S_DONE release reloads the operand on the same edge
  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_result_nxt = r_result;
    case (r_state)
      S_IDLE: begin
        if (s) begin
          w_state_nxt = S_COUNT;
        end else begin
          w_a_nxt      = A;
          w_result_nxt = '0;
        end
      end
      S_COUNT: begin
        if (r_a != '0) begin
          w_a_nxt      = r_a >> 1;
          w_result_nxt = r_result + W'(r_a[0]);
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (!s) begin
          w_state_nxt  = S_IDLE;
          w_a_nxt      = A;
          w_result_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath registers; done is registered from the next state so it equals state == S_DONE
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_a      <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_a      <= w_a_nxt;
      r_result <= w_result_nxt;
      r_done   <= (w_state_nxt == S_DONE);
    end
  end

  assign result = r_result;
  assign done   = r_done;

endmodule

// File: doc/bit_counter.md
# bit_counter

Sequential ones-counter for the datapath/controller exercises. It consumes the parallel operand held in an upstream enabled register and counts the 1 bits by repeated right shift under an ASM-style controller. The count is reported on `result` with a level `done` handshake. The block contains its own operand shift register, count register and control FSM; the `result`/`done` pair feeds downstream display or capture logic.

## Interface
- `N`, default 8: operand width in bits, N ≥ 2.
- `W`, default `$clog2(N+1)`: result width, wide enough to hold N; not overridden by instantiators.

- `Clock`: input, 1 bit. System clock, 50 MHz; all state changes on the rising edge.
- `Resetn`: input, 1 bit. Asynchronous, active-low reset.
- `A`: input, N bits. Operand, driven from the upstream register.
- `s`: input, 1 bit. Start/acknowledge level: 1 = start/hold, 0 = release.
- `result`: output, W bits. Number of 1 bits in the captured operand.
- `done`: output, 1 bit. High while a valid result is presented.

## Operation
Internal registers:
- `A_reg` (N bits): operand shift register.
- `result` (W bits): count register.
- `state`: S_IDLE, S_COUNT or S_DONE.

Reset (`Resetn` = 0, asynchronous, any state): `state` = S_IDLE, `A_reg` = 0, `result` = 0, `done` = 0.

S_IDLE:
- `done` = 0.
- Every edge with `s` = 0: `A_reg` <= `A`, `result` <= 0; stay in S_IDLE.
- Edge with `s` = 1: go to S_COUNT. `A_reg` and `result` are not modified, so the operand is the value captured on the last S_IDLE edge with `s` = 0 (0 if none since reset).

S_COUNT:
- `done` = 0. `A` and `s` are ignored.
- Edge with `A_reg` ≠ 0: `A_reg` <= `A_reg` >> 1 (zero fill), `result` <= `result` + `A_reg[0]`; stay in S_COUNT.
- Edge with `A_reg` = 0: go to S_DONE; registers are unchanged.

S_DONE:
- `done` = 1. `result` holds. `A` is ignored.
- Edge with `s` = 1: stay in S_DONE.
- Edge with `s` = 0: go to S_IDLE. `A_reg` <= `A` and `result` <= 0 on that same edge, so S_IDLE's load rule also applies on entry.

Output and arithmetic rules:
- `done` is a Moore output, `state` == S_DONE, with no combinational path from `s`.
- `result` is registered and never exceeds N; no overflow is possible with the given W.
- Unreachable state encodings return to S_IDLE on the next edge.

## Timing
Let e0 be the edge at which S_IDLE samples `s` = 1, and let k = (index of the most-significant 1 in the operand) + 1, with k = 0 for a zero operand.
- Edges e1..ek: shift cycles.
- Edge e(k+1): transition to S_DONE. `done` rises after e(k+1).
- Total: k+1 cycles from e0; best case 1 cycle (operand 0), worst case N+1 cycles.
- `result` holds its final value from edge ek (from e0 if k = 0) onward.
- `done` falls on the first edge after `s` is sampled 0 in S_DONE.
- A new start requires at least one S_IDLE edge with `s` = 0 (operand capture) before `s` = 1.
- If `s` stays 1 from reset release, the block counts operand 0: `done` after 2 edges, `result` = 0.
- Asserting `Resetn` mid-count aborts immediately: `done` = 0 and `result` = 0 without waiting for an edge.

## Test plan
- N=8, A=8'h00, s 0→1: `done` rises after e1, `result` = 0; `s` → 0 gives `done` = 0 after the next edge.
- A=8'hFF: `result` = 8, `done` after e9; `result` steps 1..8 on e1..e8.
- A=8'b1001_0100, then change A to 8'hFF after e0: `result` = 3, `done` after e9, showing the operand change during S_COUNT is ignored.
- A=8'b0000_0101, hold `s` = 1 for 10 extra cycles while toggling A: `done` stays 1 and `result` stays 2. Then `s` = 0 and A=8'h81, restart: `result` = 2 for the new operand, `done` after e9.
- `s` = 1 at reset release with A=8'h0F: `result` = 0 and `done` after 2 edges, because no capture occurred.
- A=8'hF0, pulse `Resetn` low asynchronously mid-edge after e3: `done` = 0 and `result` = 0 immediately; after release with `s` = 0, the state is S_IDLE and the next start counts a freshly captured A.
